// File: rtl/audio_out.sv
// Sample-rate tick generator, double-buffered sample register and first-order
// delta-sigma DAC. Optional status counters enabled by AUDIO_OUT_STATUS_CNT_EN.
module audio_out #(
   parameter int unsigned CLK_DIV = 1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic        sample_tick_o,
   input  logic        audio_valid_i,
   input  logic [15:0] audio_i,
   output logic        audio_o,
   output logic        underrun_o,
   output logic        overrun_o,
   input  logic        clr_cnt_i,
   output logic [7:0]  underrun_cnt_o,
   output logic [7:0]  overrun_cnt_o
);

   localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

   logic [15:0] tick_cnt;
   logic [15:0] pending_q;
   logic [15:0] active_q;
   logic [15:0] acc_q;
   logic        pend_full_q;
   logic        priming_q;
   logic [16:0] dsm_sum;
   logic        transfer;
   logic        underrun_d;
   logic        overrun_d;

   // Offset-binary conversion of the signed sample gives the DSM its duty cycle.
   assign dsm_sum    = {1'b0, acc_q} + {1'b0, active_q ^ 16'h8000};
   assign transfer   = sample_tick_o & pend_full_q;
   assign underrun_d = en_i & sample_tick_o & ~pend_full_q & ~priming_q;
   assign overrun_d  = en_i & audio_valid_i & pend_full_q & ~sample_tick_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt      <= '0;
         sample_tick_o <= 1'b0;
         pending_q     <= '0;
         active_q      <= '0;
         pend_full_q   <= 1'b0;
         priming_q     <= 1'b1;
         acc_q         <= '0;
         audio_o       <= 1'b0;
         underrun_o    <= 1'b0;
         overrun_o     <= 1'b0;
      end else if (!en_i) begin
         tick_cnt      <= '0;
         sample_tick_o <= 1'b0;
         pending_q     <= '0;
         active_q      <= '0;
         pend_full_q   <= 1'b0;
         priming_q     <= 1'b1;
         acc_q         <= '0;
         audio_o       <= 1'b0;
         underrun_o    <= 1'b0;
         overrun_o     <= 1'b0;
      end else begin
         tick_cnt      <= (tick_cnt == LastCnt) ? 16'd0 : tick_cnt + 16'd1;
         sample_tick_o <= (tick_cnt == LastCnt);
         if (transfer) begin
            active_q <= pending_q;
         end
         // A coincident valid refills pending after the transfer, so the flag stays set.
         if (audio_valid_i) begin
            pending_q   <= audio_i;
            pend_full_q <= 1'b1;
         end else if (transfer) begin
            pend_full_q <= 1'b0;
         end
         if (sample_tick_o) begin
            priming_q <= 1'b0;
         end
         acc_q      <= dsm_sum[15:0];
         audio_o    <= dsm_sum[16];
         underrun_o <= underrun_d;
         overrun_o  <= overrun_d;
      end
   end

`ifdef AUDIO_OUT_STATUS_CNT_EN
   // Counters follow the pulse conditions so they hold whenever the block is idle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         underrun_cnt_o <= '0;
         overrun_cnt_o  <= '0;
      end else if (clr_cnt_i) begin
         underrun_cnt_o <= '0;
         overrun_cnt_o  <= '0;
      end else begin
         if (underrun_d && (underrun_cnt_o != 8'hFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 8'd1;
         end
         if (overrun_d && (overrun_cnt_o != 8'hFF)) begin
            overrun_cnt_o <= overrun_cnt_o + 8'd1;
         end
      end
   end
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt_i;
   assign underrun_cnt_o = '0;
   assign overrun_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_audio_out.sv
// Self-checking bench for audio_out: a sample-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_audio_out;

   localparam int CLK_DIV = 1000;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        en;
   logic        audio_valid;
   logic [15:0] audio_in;
   logic        clr_cnt;
   logic        sample_tick;
   logic        audio_bit;
   logic        underrun;
   logic        overrun;
   logic [7:0]  underrun_cnt;
   logic [7:0]  overrun_cnt;

   int checks = 0;
   int errors = 0;
   int tick_log[$];
   int under_log[$];
   int over_log[$];

   always #5 clk = ~clk;

   audio_out #(.CLK_DIV(CLK_DIV)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .en_i           (en),
      .sample_tick_o  (sample_tick),
      .audio_valid_i  (audio_valid),
      .audio_i        (audio_in),
      .audio_o        (audio_bit),
      .underrun_o     (underrun),
      .overrun_o      (overrun),
      .clr_cnt_i      (clr_cnt),
      .underrun_cnt_o (underrun_cnt),
      .overrun_cnt_o  (overrun_cnt)
   );

   // Reference model: m_n counts enabled cycles, m_sum is the running total of
   // offset samples, and each output bit is one 65536 boundary crossing.
   int          m_n, nx_n;
   logic        m_tick, nx_tick;
   logic [15:0] m_pend, nx_pend;
   logic [15:0] m_active, nx_active;
   logic        m_pf, nx_pf;
   logic        m_prime, nx_prime;
   longint      m_sum, nx_sum;
   logic        m_audio, nx_audio;
   logic        m_under, nx_under;
   logic        m_over, nx_over;
   logic [7:0]  m_ucnt, nx_ucnt;
   logic [7:0]  m_ocnt, nx_ocnt;

   always_comb begin
      nx_n = m_n; nx_tick = m_tick; nx_pend = m_pend; nx_active = m_active;
      nx_pf = m_pf; nx_prime = m_prime; nx_sum = m_sum; nx_audio = m_audio;
      nx_under = 1'b0; nx_over = 1'b0; nx_ucnt = m_ucnt; nx_ocnt = m_ocnt;
      if (!en) begin
         nx_n = 0; nx_tick = 1'b0; nx_pend = '0; nx_active = '0; nx_pf = 1'b0;
         nx_prime = 1'b1; nx_sum = 0; nx_audio = 1'b0;
      end else begin
         nx_n     = m_n + 1;
         nx_tick  = (nx_n % CLK_DIV) == 0;
         nx_sum   = m_sum + longint'(m_active ^ 16'h8000);
         nx_audio = (nx_sum >> 16) != (m_sum >> 16);
         nx_under = m_tick && !m_pf && !m_prime;
         nx_over  = audio_valid && m_pf && !m_tick;
         if (m_tick) nx_prime = 1'b0;
         if (m_tick && m_pf) nx_active = m_pend;
         if (audio_valid) begin
            nx_pend = audio_in;
            nx_pf   = 1'b1;
         end else if (m_tick) begin
            nx_pf = 1'b0;
         end
      end
`ifdef AUDIO_OUT_STATUS_CNT_EN
      if (clr_cnt) begin
         nx_ucnt = '0;
         nx_ocnt = '0;
      end else begin
         if (nx_under && m_ucnt != 8'd255) nx_ucnt = m_ucnt + 8'd1;
         if (nx_over && m_ocnt != 8'd255) nx_ocnt = m_ocnt + 8'd1;
      end
`else
      nx_ucnt = '0;
      nx_ocnt = '0;
`endif
   end

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         m_n <= 0; m_tick <= 1'b0; m_pend <= '0; m_active <= '0; m_pf <= 1'b0;
         m_prime <= 1'b1; m_sum <= 0; m_audio <= 1'b0; m_under <= 1'b0;
         m_over <= 1'b0; m_ucnt <= '0; m_ocnt <= '0;
      end else begin
         m_n <= nx_n; m_tick <= nx_tick; m_pend <= nx_pend; m_active <= nx_active;
         m_pf <= nx_pf; m_prime <= nx_prime; m_sum <= nx_sum; m_audio <= nx_audio;
         m_under <= nx_under; m_over <= nx_over; m_ucnt <= nx_ucnt; m_ocnt <= nx_ocnt;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual,
                  expected, m_n);
      end
   endtask

   always @(negedge clk) begin
      if (rst_ni) begin
         checkOutput("outputs",
                     {12'h0, sample_tick, audio_bit, underrun, overrun, underrun_cnt, overrun_cnt},
                     {12'h0, m_tick, m_audio, m_under, m_over, m_ucnt, m_ocnt});
         if (sample_tick) tick_log.push_back(m_n);
         if (underrun) under_log.push_back(m_n);
         if (overrun) over_log.push_back(m_n);
      end
   end

   task automatic waitCycle(input int k);
      int guard;
      guard = 0;
      while (m_n < k && guard < 20000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (m_n < k) checkOutput("wait_timeout", m_n, k);
   endtask

   task automatic applyStimulus(input int k, input logic [15:0] d);
      waitCycle(k);
      audio_valid = 1'b1;
      audio_in    = d;
      @(posedge clk);
      #1;
      audio_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int ones;
      logic [7:0] exp_cnt;
      rst_ni = 1'b0; en = 1'b1; audio_valid = 1'b0; audio_in = '0; clr_cnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {12'h0, sample_tick, audio_bit, underrun, overrun, underrun_cnt, overrun_cnt}, 32'h0);
      rst_ni = 1'b1;

      // Two strobes in one period: one overrun, the later sample wins at tick 2.
      applyStimulus(1200, 16'h1234);
      applyStimulus(1300, 16'h5678);
      waitCycle(2500);
      checkOutput("model_active_5678", m_active, 32'h5678);
      checkOutput("overrun_pulse_count", over_log.size(), 1);
      checkOutput("overrun_pulse_cycle", over_log[0], 1301);

      waitCycle(3500);
      checkOutput("tick_count_first3", tick_log.size(), 3);
      checkOutput("tick_0", tick_log[0], 1000);
      checkOutput("tick_1", tick_log[1], 2000);
      checkOutput("tick_2", tick_log[2], 3000);
      checkOutput("underrun_pulse_count", under_log.size(), 1);
      checkOutput("underrun_pulse_cycle", under_log[0], 3001);
`ifdef AUDIO_OUT_STATUS_CNT_EN
      exp_cnt = 8'd1;
`else
      exp_cnt = 8'd0;
`endif
      checkOutput("underrun_cnt_one", underrun_cnt, exp_cnt);

      // Valid coincident with tick 4: old pending transfers, new one stays queued.
      applyStimulus(3600, 16'h0100);
      applyStimulus(4000, 16'h0200);
      waitCycle(4100);
      checkOutput("model_active_0100", m_active, 32'h0100);
      checkOutput("model_pend_0200", m_pend, 32'h0200);
      checkOutput("no_overrun_on_tick", over_log.size(), 1);

      // Full-scale positive: 65535 ones in any 65536-cycle window.
      applyStimulus(5500, 16'h7FFF);
      waitCycle(6002);
      ones = 0;
      for (int i = 0; i < 65536; i++) begin
         ones += int'(audio_bit);
         @(posedge clk);
         #1;
      end
      checkOutput("ones_7fff", ones, 65535);

      applyStimulus(72100, 16'h8000);
      waitCycle(73002);
      ones = 0;
      for (int i = 0; i < 4096; i++) begin
         ones += int'(audio_bit);
         @(posedge clk);
         #1;
      end
      checkOutput("ones_8000", ones, 0);

      // 301 back-to-back strobes inside one period yield 300 overruns.
      for (int i = 0; i < 301; i++) applyStimulus(77110 + i, 16'(i));
      waitCycle(77500);
`ifdef AUDIO_OUT_STATUS_CNT_EN
      exp_cnt = 8'd255;
`else
      exp_cnt = 8'd0;
`endif
      checkOutput("overrun_cnt_saturated", overrun_cnt, exp_cnt);
      waitCycle(77600);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
      waitCycle(77602);
      checkOutput("overrun_cnt_cleared", overrun_cnt, 0);
      checkOutput("underrun_cnt_cleared", underrun_cnt, 0);

      // Reset in mid-period: the next tick comes a full period after release.
      waitCycle(78500);
      rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tick_log.delete();
      under_log.delete();
      rst_ni = 1'b1;
      waitCycle(1005);
      checkOutput("reset_tick_count", tick_log.size(), 1);
      checkOutput("reset_tick_cycle", tick_log[0], 1000);
      checkOutput("reset_no_underrun", under_log.size(), 0);

      // Disable then re-enable: idle outputs, then priming again on the first tick.
      en = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("disabled_idle", {sample_tick, audio_bit, underrun, overrun}, 0);
      tick_log.delete();
      under_log.delete();
      en = 1'b1;
      waitCycle(1005);
      checkOutput("reenable_tick_cycle", tick_log[0], 1000);
      checkOutput("reenable_no_underrun", under_log.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
